// File: rtl/g15_mem_pkg.sv
// Shared G-15 drum geometry and the whole-line clear sequencer state encoding.
package g15_mem_pkg;

  localparam int G15_WORD_BITS      = 29;
  localparam int G15_LONG_WORDS     = 108;
  localparam int G15_LONG_TRACK_LEN = G15_WORD_BITS * G15_LONG_WORDS;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CLEARING,
    DONE
  } clr_state_t;

endpackage

// File: rtl/drum_track.sv
// One recirculating drum track: an N-bit serial delay line, a bit entered now reappears N cycles later.
module drum_track #(
  parameter int N = 3132
) (
  input  logic clk,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sr_q;

  // NOTE: track storage has no reset on purpose -- contents survive rst like a real drum,
  // and leaving thousands of flops off the reset tree keeps them plain shift cells.
  always_ff @(posedge clk) begin
    sr_q <= {sr_q[N-2:0], d_i};
  end

  assign q_o = sr_q[N-1];

endmodule

// File: rtl/line_clear_ctl.sv
// Whole-line clear sequencer: validates a request, waits for drum origin, then zeroes one full revolution.
module line_clear_ctl
  import g15_mem_pkg::*;
#(
  parameter int N_LINES   = 8,
  parameter int SEL_W     = 4,
  parameter int TRACK_LEN = G15_LONG_TRACK_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_req_i,
  input  logic [SEL_W-1:0]   clr_line_i,
  input  logic [N_LINES-1:0] wp_i,
  input  logic               origin_i,
  output logic               clr_busy_o,
  output logic               clr_done_o,
  output logic               clr_err_o,
  output logic               clr_wr_o,
  output logic [SEL_W-1:0]   clr_line_o
);

  localparam int CNT_W = $clog2(TRACK_LEN);
  localparam int NSEL  = 1 << SEL_W;

  clr_state_t       state_q, state_d;
  logic [SEL_W-1:0] line_q, line_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [NSEL-1:0]  wp_ext;
  logic             reject;

  assign wp_ext = NSEL'(wp_i);
  assign reject = ({1'b0, clr_line_i} >= (SEL_W+1)'(N_LINES)) || wp_ext[clr_line_i];

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    clr_busy_o = 1'b0;
    clr_done_o = 1'b0;
    clr_wr_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_req_i) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            line_d  = clr_line_i;
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        clr_busy_o = 1'b1;
        // The origin cycle itself is the first bit cleared.
        if (origin_i) begin
          clr_wr_o = 1'b1;
          cnt_d    = '0;
          state_d  = CLEARING;
        end
      end
      CLEARING: begin
        clr_busy_o = 1'b1;
        clr_wr_o   = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(TRACK_LEN - 2)) state_d = DONE;
      end
      DONE: begin
        clr_done_o = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      line_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign clr_err_o  = err_q;
  assign clr_line_o = line_q;

endmodule

// File: rtl/mem_long_bank.sv
// Bank of G-15 long lines: local drum tracks, external lines via CD, drum position, write protect, line clear.
module mem_long_bank
  import g15_mem_pkg::*;
#(
  parameter int N_LINES   = 8,
  parameter int N_EXT     = 2,
  parameter int WORD_BITS = G15_WORD_BITS,
  parameter int WORDS     = G15_LONG_WORDS,
  parameter int SEL_W     = 4
) (
  input  logic                           CLOCK,
  input  logic                           rst,
  input  logic                           CD_LD,
  input  logic [SEL_W-1:0]               CD_IN,
  input  logic                           CD_PRESET,
  input  logic                           CD_CLR,
  input  logic                           D_EN,
  input  logic [SEL_W-1:0]               D_SEL,
  input  logic                           TR,
  input  logic                           LB,
  input  logic                           S_EN,
  input  logic [N_LINES-1:0]             WP,
  input  logic [(N_EXT>0 ? N_EXT:1)-1:0] EXT_M,
  input  logic                           CLR_REQ,
  input  logic [SEL_W-1:0]               CLR_LINE,
  output logic [N_LINES-1:0]             M,
  output logic [N_LINES-1:0]             EB,
  output logic                           MC_not,
  output logic [SEL_W-1:0]               CD,
  output logic [$clog2(WORD_BITS)-1:0]   BIT_T,
  output logic [$clog2(WORDS)-1:0]       WORD,
  output logic                           ORIGIN,
  output logic                           CLR_BUSY,
  output logic                           CLR_DONE,
  output logic                           CLR_ERR
);

  localparam int TRACK_LEN = WORDS * WORD_BITS;
  localparam int BIT_W     = $clog2(WORD_BITS);
  localparam int WORD_W    = $clog2(WORDS);
  localparam int NSEL      = 1 << SEL_W;

  logic [SEL_W-1:0]  cd_q, cd_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [N_LINES-1:0] trk_d;
  logic [NSEL-1:0]   sel_vec;
  logic              clr_wr;
  logic [SEL_W-1:0]  clr_line;

  always_comb begin
    cd_d = cd_q;
    if (CD_CLR)         cd_d = '0;
    else if (CD_PRESET) cd_d = '1;
    else if (CD_LD)     cd_d = CD_IN;
  end

  always_comb begin
    bit_d  = bit_q + 1'b1;
    word_d = word_q;
    if (bit_q == BIT_W'(WORD_BITS - 1)) begin
      bit_d  = '0;
      word_d = (word_q == WORD_W'(WORDS - 1)) ? '0 : word_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      cd_q   <= '0;
      bit_q  <= '0;
      word_q <= '0;
    end else begin
      cd_q   <= cd_d;
      bit_q  <= bit_d;
      word_q <= word_d;
    end
  end

  assign CD     = cd_q;
  assign BIT_T  = bit_q;
  assign WORD   = word_q;
  assign ORIGIN = (bit_q == '0) && (word_q == '0);

  line_clear_ctl #(
    .N_LINES  (N_LINES),
    .SEL_W    (SEL_W),
    .TRACK_LEN(TRACK_LEN)
  ) u_clr (
    .clk       (CLOCK),
    .rst       (rst),
    .clr_req_i (CLR_REQ),
    .clr_line_i(CLR_LINE),
    .wp_i      (WP),
    .origin_i  (ORIGIN),
    .clr_busy_o(CLR_BUSY),
    .clr_done_o(CLR_DONE),
    .clr_err_o (CLR_ERR),
    .clr_wr_o  (clr_wr),
    .clr_line_o(clr_line)
  );

  // Clear beats a destination write; a destination code past the local lines matches nothing.
  always_comb begin
    for (int i = 0; i < N_LINES; i++) begin
      if (clr_wr && (clr_line == SEL_W'(i)))
        trk_d[i] = 1'b0;
      else if (D_EN && TR && (D_SEL == SEL_W'(i)) && !WP[i])
        trk_d[i] = LB;
      else
        trk_d[i] = M[i];
    end
  end

  for (genvar g = 0; g < N_LINES; g++) begin : g_track
    drum_track #(.N(TRACK_LEN)) u_track (
      .clk(CLOCK),
      .d_i(trk_d[g]),
      .q_o(M[g])
    );
    assign EB[g] = M[g] & S_EN & (cd_q == SEL_W'(g));
  end

  always_comb begin
    sel_vec = '0;
    for (int i = 0; i < N_LINES; i++) sel_vec[i] = M[i];
    for (int j = 0; j < N_EXT; j++)   sel_vec[N_LINES + j] = EXT_M[j];
  end

  assign MC_not = ~sel_vec[cd_q];

endmodule

// File: tb/tb_mem_long_bank.sv
// Directed self-checking bench for mem_long_bank at default geometry (8 lines, 2 external, 3132-bit tracks).
module tb_mem_long_bank;

  localparam int TL = 3132;

  logic       CLOCK = 1'b0;
  logic       rst = 1'b1;
  logic       CD_LD = 0, CD_PRESET = 0, CD_CLR = 0;
  logic [3:0] CD_IN = '0, D_SEL = '0, CLR_LINE = '0;
  logic       D_EN = 0, TR = 0, LB = 0, S_EN = 0, CLR_REQ = 0;
  logic [7:0] WP = '0;
  logic [1:0] EXT_M = '0;
  logic [7:0] M, EB;
  logic       MC_not, ORIGIN, CLR_BUSY, CLR_DONE, CLR_ERR;
  logic [3:0] CD;
  logic [4:0] BIT_T;
  logic [6:0] WORD;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  mem_long_bank dut (
    .CLOCK(CLOCK), .rst(rst), .CD_LD(CD_LD), .CD_IN(CD_IN), .CD_PRESET(CD_PRESET),
    .CD_CLR(CD_CLR), .D_EN(D_EN), .D_SEL(D_SEL), .TR(TR), .LB(LB), .S_EN(S_EN),
    .WP(WP), .EXT_M(EXT_M), .CLR_REQ(CLR_REQ), .CLR_LINE(CLR_LINE), .M(M), .EB(EB),
    .MC_not(MC_not), .CD(CD), .BIT_T(BIT_T), .WORD(WORD), .ORIGIN(ORIGIN),
    .CLR_BUSY(CLR_BUSY), .CLR_DONE(CLR_DONE), .CLR_ERR(CLR_ERR)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_pos(input int w, input int b);
    for (int k = 0; k < TL + 10; k++) begin
      if (WORD == 7'(w) && BIT_T == 5'(b)) break;
      tick();
    end
    check("wait_pos", {WORD, BIT_T}, {7'(w), 5'(b)});
  endtask

  task automatic wait_origin();
    for (int k = 0; k < TL + 10; k++) begin
      if (ORIGIN) break;
      tick();
    end
    check("wait_origin", ORIGIN, 1);
  endtask

  task automatic fill_line2();
    wait_origin();
    D_EN = 1; TR = 1; D_SEL = 4'd2; LB = 1;
    repeat (TL) tick();
    D_EN = 0; TR = 0; LB = 0;
  endtask

  int wc, oc, oc2, req_c, ones2, ones4, dones, bad;

  initial begin
    // Reset state
    repeat (3) @(posedge CLOCK);
    #1;
    check("rst_cd", CD, 0);
    check("rst_bit", BIT_T, 0);
    check("rst_word", WORD, 0);
    check("rst_busy", CLR_BUSY, 0);
    check("rst_done", CLR_DONE, 0);
    check("rst_err", CLR_ERR, 0);
    rst = 0;

    // Single-bit write on line 3, seen one revolution later
    wait_pos(5, 0);
    wc = cyc;
    D_EN = 1; TR = 1; D_SEL = 4'd3; LB = 1; CD_LD = 1; CD_IN = 4'd3; S_EN = 1;
    tick();
    D_EN = 0; LB = 0; CD_LD = 0;
    run_to(wc + TL - 1);
    check("m3_before", M[3], 0);
    check("mcn_before", MC_not, 1);
    tick();
    check("m3_after", M[3], 1);
    check("eb_after", EB, 8'h08);
    check("mcn_after", MC_not, 0);
    check("pos_after", {WORD, BIT_T}, {7'd5, 5'd0});

    // Write-protected line ignores both a 0 over its 1 and a 1 over its 0
    WP = 8'h08; D_EN = 1; TR = 1; D_SEL = 4'd3; LB = 0;
    tick();
    LB = 1;
    tick();
    D_EN = 0; TR = 0; LB = 0;
    run_to(wc + 2 * TL);
    check("wp_keep1", M[3], 1);
    tick();
    check("wp_keep0", M[3], 0);
    WP = '0; S_EN = 0;

    // CD priority and read-path selection
    CD_CLR = 1; CD_PRESET = 1; CD_LD = 1; CD_IN = 4'd5;
    tick();
    check("cd_clr_prio", CD, 0);
    CD_CLR = 0;
    tick();
    check("cd_preset_prio", CD, 15);
    CD_PRESET = 0; CD_LD = 0;
    check("mcn_unmapped", MC_not, 1);
    CD_LD = 1; CD_IN = 4'd9;
    tick();
    CD_LD = 0;
    check("cd_ld9", CD, 9);
    EXT_M = 2'b10; #1;
    check("mcn_ext1_hi", MC_not, 0);
    EXT_M = 2'b00; #1;
    check("mcn_ext1_lo", MC_not, 1);
    CD_LD = 1; CD_IN = 4'd8;
    tick();
    CD_LD = 0;
    EXT_M = 2'b01; #1;
    check("mcn_ext0_hi", MC_not, 0);
    EXT_M = 2'b00;

    // Clear line 2 with concurrent writes to lines 2 and 4
    fill_line2();
    wait_pos(40, 0);
    CLR_REQ = 1; CLR_LINE = 4'd2;
    tick();
    CLR_REQ = 0;
    check("clr_busy_next", CLR_BUSY, 1);
    wait_origin();
    oc = cyc;
    run_to(oc + 500);
    D_EN = 1; TR = 1; D_SEL = 4'd2; LB = 1;
    tick();
    D_EN = 0; LB = 0;
    run_to(oc + 600);
    D_EN = 1; D_SEL = 4'd4; LB = 1;
    tick();
    D_EN = 0; TR = 0; LB = 0;
    for (int k = 0; k < TL + 10; k++) begin
      if (CLR_DONE) break;
      tick();
    end
    check("clr_done_cycle", cyc - oc, TL);
    check("clr_done_pulse", CLR_DONE, 1);
    check("clr_busy_done", CLR_BUSY, 0);
    ones2 = 0; ones4 = 0; dones = 0;
    for (int j = 0; j < TL; j++) begin
      ones2 += int'(M[2]);
      ones4 += int'(M[4]);
      dones += int'(CLR_DONE);
      if (j == 600) check("line4_write", M[4], 1);
      tick();
    end
    check("line2_zero", ones2, 0);
    check("line4_ones", ones4, 1);
    check("done_once", dones, 1);

    // Rejected requests
    CLR_REQ = 1; CLR_LINE = 4'd9;
    tick();
    CLR_REQ = 0;
    check("err_range", CLR_ERR, 1);
    check("err_range_busy", CLR_BUSY, 0);
    tick();
    check("err_pulse_end", CLR_ERR, 0);
    WP = 8'h20; CLR_REQ = 1; CLR_LINE = 4'd5;
    tick();
    CLR_REQ = 0; WP = '0;
    check("err_wp", CLR_ERR, 1);
    check("err_wp_busy", CLR_BUSY, 0);

    // Request on an origin cycle, then reset 100 cycles into the clear
    fill_line2();
    check("req_on_origin", ORIGIN, 1);
    req_c = cyc;
    CLR_REQ = 1; CLR_LINE = 4'd2;
    tick();
    CLR_REQ = 0;
    check("busy_origin_req", CLR_BUSY, 1);
    tick();
    wait_origin();
    oc2 = cyc;
    check("arm_full_rev", oc2 - req_c, TL);
    run_to(oc2 + 100);
    rst = 1; #1;
    check("midrst_busy", CLR_BUSY, 0);
    check("midrst_pos", {WORD, BIT_T}, 0);
    tick();
    tick();
    check("midrst_nodone", CLR_DONE, 0);
    rst = 0;
    run_to(oc2 + TL);
    bad = 0; dones = 0;
    for (int j = 0; j < TL; j++) begin
      if (M[2] !== ((j < 100) ? 1'b0 : 1'b1)) bad++;
      dones += int'(CLR_DONE);
      tick();
    end
    check("partial_clear", bad, 0);
    check("no_done_after_rst", dones, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_long_bank.md
Name: mem_long_bank

Overview:
- Parametrised bank of G-15 long memory lines: N_LINES recirculating drum tracks plus N_EXT externally supplied lines.
- Generalises the fixed lines-0-to-6 block: variable line count, track geometry and select width.
- Adds an internal drum-position counter, per-line write protect, and a handshaked whole-line clear sequencer.
- Sits between the command-line/destination decode and the early bus / MC read path.

Parameters:
- N_LINES, 8, number of locally stored long lines (1..16).
- N_EXT, 2, number of external line inputs addressable through the CD register (0..8).
- WORD_BITS, 29, bits per word time.
- WORDS, 108, words per revolution; track length TRACK_LEN = WORDS*WORD_BITS (3132 at defaults).
- SEL_W, 4, CD register width; must satisfy 2^SEL_W >= N_LINES+N_EXT.

Ports:
- CLOCK  in  1  bit-time clock.
- rst  in  1  asynchronous, active-high reset.
- CD_LD  in  1  load CD from CD_IN.
- CD_IN  in  SEL_W  new source-line code.
- CD_PRESET  in  1  force CD to all ones (power-on ATS).
- CD_CLR  in  1  force CD to 0 (manual clear).
- D_EN  in  1  destination write enable.
- D_SEL  in  SEL_W  destination line.
- TR  in  1  transfer timing gate.
- LB  in  1  serial write data.
- S_EN  in  1  early-bus source enable.
- WP  in  N_LINES  per-line write-protect mask.
- EXT_M  in  N_EXT  external line outputs.
- CLR_REQ  in  1  clear-line request.
- CLR_LINE  in  SEL_W  line to clear.
- M  out  N_LINES  track outputs.
- EB  out  N_LINES  early-bus terms.
- MC_not  out  1  inverted bit from the CD-selected line.
- CD  out  SEL_W  current source-line code.
- BIT_T  out  $clog2(WORD_BITS)  bit position within word.
- WORD  out  $clog2(WORDS)  word position.
- ORIGIN  out  1  high when BIT_T==0 and WORD==0.
- CLR_BUSY  out  1  clear sequence in progress.
- CLR_DONE  out  1  one-cycle completion pulse.
- CLR_ERR  out  1  one-cycle rejection pulse.

Behaviour:
- Reset (async): CD=0, BIT_T=0, WORD=0, CLR_BUSY=0, CLR_DONE=0, CLR_ERR=0, clear FSM to IDLE.
  - Track contents are not reset; they persist like a drum. Simulation starts tracks at 0.
  - M, EB and MC_not are combinational from track contents and therefore follow them.
- CD register: single register, updated on CLOCK edge.
  - Priority: CD_CLR > CD_PRESET > CD_LD. None asserted: hold.
- Position counter: BIT_T increments every cycle and wraps at WORD_BITS-1. WORD increments on BIT_T wrap and wraps at WORDS-1, so ORIGIN recurs every TRACK_LEN cycles.
- Track i:
  - Write condition: WE_i = D_EN & TR & (D_SEL==i) & ~WP[i].
  - Track input = 0 if clear is active on line i, else LB if WE_i, else M[i].
  - A bit written at cycle k appears on M[i] at cycle k+TRACK_LEN.
- Read path:
  - Selected bit sel = M[CD] for CD<N_LINES; EXT_M[CD-N_LINES] for N_LINES<=CD<N_LINES+N_EXT; else 0.
  - MC_not = ~sel, purely combinational.
  - EB[i] = M[i] & S_EN & (CD==i).
- Clear FSM, states IDLE, ARMED, CLEARING, DONE:
  - IDLE: on CLR_REQ, reject when CLR_LINE>=N_LINES or WP[CLR_LINE]=1. Rejection pulses CLR_ERR for 1 cycle and stays in IDLE. Otherwise latch the line and go to ARMED. CLR_BUSY=1 from the next cycle.
  - ARMED: wait for ORIGIN, then go to CLEARING with the length counter at 0.
  - CLEARING: write 0 into the latched line for exactly TRACK_LEN cycles, starting at the ORIGIN cycle. Clear overrides LB writes to that line. Other lines operate normally. WP changes during clearing are ignored.
  - DONE: CLR_DONE=1 for 1 cycle, CLR_BUSY=0, then IDLE.
  - CLR_REQ while busy is ignored: no error, no queueing.
- Boundary conditions:
  - Request arriving on an ORIGIN cycle: ARMED waits for the next ORIGIN, a full revolution later.
  - rst mid-clear: FSM goes to IDLE and no CLR_DONE is issued. The partial clear remains on the track.
  - D_SEL>=N_LINES: no local write occurs.

Decomposition:
- Package g15_mem_pkg holds:
  - constants G15_WORD_BITS=29, G15_LONG_WORDS=108, G15_LONG_TRACK_LEN=3132;
  - typedef clr_state_t {IDLE, ARMED, CLEARING, DONE}.
- Tracks: reuse the existing drum_track (parameter N=TRACK_LEN) in a generate loop.
- New sub-module line_clear_ctl holds the clear FSM and the TRACK_LEN length counter.

Test Plan:
- Write LB=1 on line 3 at WORD 5, BIT_T 0 (CD=3, S_EN=1) -> M[3] and EB[3] high exactly 3132 cycles later, MC_not=0 that cycle, other EB stay 0.
- WP[3]=1, repeat the write -> line 3 unchanged after one revolution.
- CD_CLR, CD_PRESET and CD_LD(5) asserted together -> CD=0; CD_PRESET with CD_LD(5) -> CD=15; CD=15 with N_LINES+N_EXT=10 -> MC_not=1.
- CD=9, EXT_M=2'b10 -> MC_not=0; EXT_M=2'b00 -> MC_not=1.
- Line 2 filled with ones, CLR_REQ(2) at WORD 40 -> CLR_BUSY next cycle, clearing starts at ORIGIN, CLR_DONE exactly 3132 cycles after that ORIGIN, line 2 all zero. Concurrent LB=1 write to line 2 is lost; concurrent write to line 4 succeeds.
- CLR_REQ(9) -> CLR_ERR 1 cycle, CLR_BUSY stays 0. rst 100 cycles into CLEARING -> CLR_BUSY=0, no CLR_DONE, counters 0, first 100 bits of the track zero and the rest retain their ones.
